// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the data-memory access controller.
package mem_pkg;

    localparam int unsigned MEM_BYTES_DEF = 256;

    // Request size encodings; 2'b11 is illegal
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StResp,
        StErr
    } state_e;

    // True when the size is illegal or the byte offset breaks natural alignment
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction (loads) and lane merge (sub-word stores).
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane; offset 0 is the most significant byte
    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
    end

    // Extend the selected lane and splice store data into the old word
    always_comb begin
        o_load  = i_word;
        o_merge = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{24{i_signed & w_byte[7]}}, w_byte};
                case (i_offset)
                    2'd0:    o_merge[31:24] = i_wdata[7:0];
                    2'd1:    o_merge[23:16] = i_wdata[7:0];
                    2'd2:    o_merge[15:8]  = i_wdata[7:0];
                    default: o_merge[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                o_load = {{16{i_signed & w_half[15]}}, w_half};
                if (i_offset[1]) begin
                    o_merge[15:0] = i_wdata;
                end else begin
                    o_merge[31:16] = i_wdata;
                end
            end
            default: begin
                o_load  = i_word;
                o_merge = i_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-wide, big-endian data memory.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error,
    output logic        o_busy,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_write,
    output logic        o_mem_read,
    input  logic [31:0] i_mem_rdata
);

    state_e      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rbuf;
    logic        r_req_ready;
    logic        r_busy;
    logic        r_resp_valid;
    logic        r_resp_error;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Classify the incoming request: bad size/alignment or word beyond the last legal one
    always_comb begin
        w_err = size_misaligned(i_req_size, i_req_addr[1:0]) ||
                ({i_req_addr[31:2], 2'b00} > 32'(MEM_BYTES - 4));
    end

    mem_lane_align u_align (
        .i_word   (r_rbuf),
        .i_offset (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata[15:0]),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    // Sequencer: state, latched request, read buffer and registered handshake/strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_write      <= 1'b0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_rbuf       <= 32'h0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_err) begin
                            r_state      <= StErr;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else begin
                            r_write  <= i_req_write;
                            r_size   <= i_req_size;
                            r_signed <= i_req_signed;
                            r_addr   <= i_req_addr;
                            r_wdata  <= i_req_wdata;
                            if (i_req_write && (i_req_size == SZ_WORD)) begin
                                r_state     <= StWrite;
                                r_mem_write <= 1'b1;
                            end else begin
                                r_state    <= StRead;
                                r_mem_read <= 1'b1;
                            end
                        end
                    end
                end
                StRead: begin
                    r_rbuf <= i_mem_rdata;
                    if (r_write) begin
                        r_state     <= StWrite;
                        r_mem_write <= 1'b1;
                    end else begin
                        r_state      <= StResp;
                        r_resp_valid <= 1'b1;
                    end
                end
                StWrite: begin
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Data paths decode from registered state so they clear with reset
    always_comb begin
        o_resp_rdata     = ((r_state == StResp) && !r_write) ? w_load : 32'h0;
        o_mem_write_data = (r_size == SZ_WORD) ? r_wdata : w_merge;
    end

    assign o_req_ready   = r_req_ready;
    assign o_busy        = r_busy;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_error  = r_resp_error;
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;
    assign o_mem_address = {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a big-endian word memory model.
module tb_mem_access_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_BYTES(256)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_write      (req_write),
        .i_req_size       (req_size),
        .i_req_signed     (req_signed),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_resp_error     (resp_error),
        .o_busy           (busy),
        .o_mem_address    (mem_address),
        .o_mem_write_data (mem_write_data),
        .o_mem_write      (mem_write),
        .o_mem_read       (mem_read),
        .i_mem_rdata      (mem_rdata)
    );

    assign mem_rdata = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and observe it to completion (latency 0 means no response)
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err,
                          output int nrd, output int nwr, output logic [31:0] wseen);
        int guard;
        lat = 0; rd = 32'h0; err = 1'b0; nrd = 0; nwr = 0; wseen = 32'h0;
        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wseen = mem_write_data;
            end
            if (resp_valid) begin
                lat = n; rd = resp_rdata; err = resp_error;
                break;
            end
        end
    endtask

    int          lat, nrd, nwr;
    logic [31:0] rd, ws;
    logic        err;
    int          first_resp, ready_cyc, second_resp;
    logic [31:0] second_data;
    int          wr_in_rst;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[2] = 32'h8899AABB;

        #23;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_resp", {30'h0, resp_valid, resp_error}, 32'h0);
        check("rst_addr", mem_address, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads
        do_req(1'b0, B, 1'b1, 32'd9, 32'h0, lat, rd, err, nrd, nwr, ws);
        check("lb9_data", rd, 32'hFFFFFF99);
        check("lb9_lat", lat, 2);
        check("lb9_nwr", nwr, 0);
        check("lb9_err", {31'h0, err}, 32'h0);
        do_req(1'b0, H, 1'b0, 32'd10, 32'h0, lat, rd, err, nrd, nwr, ws);
        check("lhu10_data", rd, 32'h0000AABB);
        do_req(1'b0, W, 1'b0, 32'd8, 32'h0, lat, rd, err, nrd, nwr, ws);
        check("lw8_data", rd, 32'h8899AABB);
        check("lw8_lat", lat, 2);

        // Sub-word store: read-modify-write
        do_req(1'b1, B, 1'b0, 32'd8, 32'h00000012, lat, rd, err, nrd, nwr, ws);
        check("sb8_lat", lat, 3);
        check("sb8_nrd", nrd, 1);
        check("sb8_nwr", nwr, 1);
        check("sb8_wdata", ws, 32'h1299AABB);
        check("sb8_rdata", rd, 32'h0);
        check("sb8_mem", mem[2], 32'h1299AABB);

        // Word store restores word 8
        do_req(1'b1, W, 1'b0, 32'd8, 32'h8899AABB, lat, rd, err, nrd, nwr, ws);
        check("sw8_lat", lat, 2);
        check("sw8_nrd", nrd, 0);
        check("sw8_mem", mem[2], 32'h8899AABB);

        // Error cases
        do_req(1'b1, W, 1'b0, 32'd6, 32'hCAFEF00D, lat, rd, err, nrd, nwr, ws);
        check("sw6_err", {31'h0, err}, 32'h1);
        check("sw6_lat", lat, 1);
        check("sw6_mem", {nrd[15:0], nwr[15:0]}, 32'h0);
        check("sw6_mem1", mem[1], 32'h0);
        do_req(1'b0, H, 1'b0, 32'd3, 32'h0, lat, rd, err, nrd, nwr, ws);
        check("lh3_err", {31'h0, err}, 32'h1);
        check("lh3_rdata", rd, 32'h0);
        check("lh3_mem", {nrd[15:0], nwr[15:0]}, 32'h0);
        do_req(1'b0, X, 1'b0, 32'd8, 32'h0, lat, rd, err, nrd, nwr, ws);
        check("sz11_err", {31'h0, err}, 32'h1);
        check("sz11_lat", lat, 1);
        do_req(1'b0, W, 1'b0, 32'd256, 32'h0, lat, rd, err, nrd, nwr, ws);
        check("lw256_err", {31'h0, err}, 32'h1);
        check("lw256_mem", {nrd[15:0], nwr[15:0]}, 32'h0);
        do_req(1'b0, W, 1'b0, 32'd252, 32'h0, lat, rd, err, nrd, nwr, ws);
        check("lw252_ok", {31'h0, err}, 32'h0);
        check("mem8_after_err", mem[2], 32'h8899AABB);

        // Reset during READ of a half store
        @(negedge clk);
        req_write = 1'b1; req_size = H; req_addr = 32'd8; req_wdata = 32'h00005566;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_read", {31'h0, mem_read}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rr_ready", {31'h0, req_ready}, 32'h1);
        check("rr_outs", {27'h0, busy, mem_read, mem_write, resp_valid, resp_error}, 32'h0);
        check("rr_rdata", resp_rdata, 32'h0);
        check("rr_addr", mem_address, 32'h0);
        wr_in_rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_write || resp_valid) wr_in_rst++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_write || resp_valid) wr_in_rst++;
        end
        check("rr_no_write", wr_in_rst, 0);
        check("rr_mem8", mem[2], 32'h8899AABB);

        // Back-to-back with req_valid held
        first_resp = 0; ready_cyc = 0; second_resp = 0; second_data = 32'h0;
        @(negedge clk);
        req_write = 1'b1; req_size = W; req_addr = 32'd0; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (resp_valid && first_resp == 0) first_resp = n;
            else if (resp_valid && second_resp == 0) begin
                second_resp = n;
                second_data = resp_rdata;
            end
            if (req_ready && ready_cyc == 0 && first_resp != 0) ready_cyc = n;
            if (n == ready_cyc) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b_first", first_resp, 2);
        check("b2b_ready", ready_cyc, 3);
        check("b2b_second", second_resp, 5);
        check("b2b_data", second_data, 32'hDEADBEEF);
        check("b2b_mem0", mem[0], 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
